// File: rtl/fifo_checker.sv
// fifo_checker: reads an incrementing-word stream from a FIFO, counts sequence
// breaks and reports the first one. Define FIFO_CHECKER_THROTTLE_EN to limit
// reads to the upper half of every 8-cycle window.
module fifo_checker #(
    parameter int          DW        = 64,
    parameter int unsigned NUM_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          empty,
    input  logic [DW-1:0] rdata,
    output logic          ren,
    output logic          done,
    output logic          pass,
    output logic [15:0]   err_cnt,
    output logic [DW-1:0] first_exp,
    output logic [DW-1:0] first_got
);
    typedef enum logic [1:0] {IDLE, ARM, CHECK, DONE} state_t;

    state_t        state, state_nxt;
    logic          rvalid, gate, active, consume, last, miss;
    logic [31:0]   issued, checked;
    logic [DW-1:0] expected;
    logic [15:0]   err_nxt;

`ifdef FIFO_CHECKER_THROTTLE_EN
    logic [2:0] thr_cnt;

    // free-running phase counter; its top bit opens the read window
    always_ff @(posedge clk) begin
        if (!rstn) thr_cnt <= '0;
        else       thr_cnt <= thr_cnt + 3'd1;
    end

    assign gate = thr_cnt[2];
`else
    assign gate = 1'b1;
`endif

    assign active  = state == ARM || state == CHECK;
    assign ren     = rstn & ~empty & gate & active & (issued < NUM_WORDS);
    // a word still in flight when en falls is consumed in IDLE as a compare
    assign consume = rvalid && state != DONE;
    assign last    = consume && checked == NUM_WORDS - 1;
    assign miss    = consume && state != ARM && rdata != expected;
    assign err_nxt = (miss && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;

    // state register
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state: run control from en, completion overrides everything
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = ARM;
            ARM:     state_nxt = !en ? IDLE : rvalid ? CHECK : ARM;
            CHECK:   if (!en) state_nxt = IDLE;
            default: state_nxt = DONE;
        endcase
        if (last) state_nxt = DONE;
    end

    // read tracking, sequence checking and result registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rvalid    <= 1'b0;
            issued    <= '0;
            checked   <= '0;
            expected  <= '0;
            err_cnt   <= '0;
            first_exp <= '0;
            first_got <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            rvalid <= ren;
            if (ren) issued <= issued + 32'd1;
            if (consume) begin
                checked <= checked + 32'd1;
                // load, match and resync all leave the next expected at rdata+1
                expected <= rdata + 1'b1;
                err_cnt  <= err_nxt;
                if (miss && err_cnt == 16'd0) begin
                    first_exp <= expected;
                    first_got <= rdata;
                end
            end
            if (last) done <= 1'b1;
            pass <= (done | last) & (err_nxt == 16'd0);
        end
    end
endmodule

// File: tb/tb_fifo_checker.sv
// tb_fifo_checker: FIFO model feeding the checker, results compared with a
// stream-level reference computed from the words actually delivered.
module tb_fifo_checker;
    localparam int DW = 64;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rstn, en, empty;
    logic [DW-1:0] rdata;
    logic          ren, done, pass;
    logic [15:0]   err_cnt;
    logic [DW-1:0] first_exp, first_got;

    logic [DW-1:0] fifo [$];
    logic [DW-1:0] sent [$];
    int            vectors = 0, miscompares = 0;
    int            ren_cycles, viol, cyc;
    logic          pop_pending, hold;
    logic [2:0]    thr;

    fifo_checker #(.DW(DW), .NUM_WORDS(NW)) dut (
        .clk(clk), .rstn(rstn), .en(en), .empty(empty), .rdata(rdata),
        .ren(ren), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_exp(first_exp), .first_got(first_got)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one clock cycle, entered and left at a falling edge
    task automatic step(input int gap);
        if (pop_pending) begin
            rdata = fifo.pop_front();
            sent.push_back(rdata);
            pop_pending = 1'b0;
        end
        hold  = gap == 1 ? cyc[0] : gap == 2 ? ($urandom_range(0, 2) == 0) : 1'b0;
        empty = hold | (fifo.size() == 0);
        #1;
        if (ren) begin
            ren_cycles++;
            pop_pending = 1'b1;
        end
        if (ren & empty) viol++;
`ifdef FIFO_CHECKER_THROTTLE_EN
        if (ren && !thr[2]) viol++;
`endif
        cyc++;
        thr = thr + 3'd1;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        en = 1'b0;
        empty = 1'b1;
        pop_pending = 1'b0;
        fifo.delete();
        sent.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        thr = 3'd0;
        ren_cycles = 0;
        viol = 0;
    endtask

    task automatic run(input int gap);
        int n = 0;
        en = 1'b1;
        while (!done && n < 400) begin
            step(gap);
            n++;
        end
    endtask

    // reference: word i (not a load) must equal word i-1 plus one, modulo 2^DW
    task automatic expect_run(input string tag, input int load2);
        int            e = 0;
        logic [DW-1:0] fe = '0, fg = '0;
        int            r;
        for (int i = 1; i < sent.size(); i++) begin
            if (i != load2 && sent[i] !== sent[i-1] + 64'd1) begin
                if (e == 0) begin
                    fe = sent[i-1] + 64'd1;
                    fg = sent[i];
                end
                if (e < 65535) e++;
            end
        end
        check({tag, ".done"}, done, 1);
        check({tag, ".words"}, sent.size(), NW);
        check({tag, ".reads"}, ren_cycles, NW);
        check({tag, ".err_cnt"}, err_cnt, e);
        check({tag, ".first_exp"}, first_exp, fe);
        check({tag, ".first_got"}, first_got, fg);
        check({tag, ".pass"}, pass, e == 0);
        check({tag, ".ren_vs_empty"}, viol, 0);
        r = ren_cycles;
        fifo.push_back(64'h1);
        fifo.push_back(64'h2);
        repeat (4) step(0);
        check({tag, ".no_read_after_done"}, ren_cycles, r);
        check({tag, ".done_held"}, done, 1);
    endtask

    initial begin
        logic [DW-1:0] w;
        int            n;
        rdata = '0;
        cyc = 0;
        thr = 3'd0;
        @(negedge clk);

        reset_dut();
        for (int i = 0; i < 4; i++) fifo.push_back(64'(i));
        repeat (3) step(0);
        check("reset.ren_idle", ren_cycles, 0);
        check("reset.done", done, 0);
        check("reset.pass", pass, 0);
        check("reset.err_cnt", err_cnt, 0);
        check("reset.first_exp", first_exp, 0);
        check("reset.first_got", first_got, 0);

        reset_dut();
        for (int i = 0; i < NW; i++) fifo.push_back(64'h1234_5678 + 64'(i));
        run(0);
        check("contig.err_cnt0", err_cnt, 0);
        expect_run("contig", -1);

        reset_dut();
        for (int i = 0; i < NW; i++) fifo.push_back(i == 5 ? 64'hDEAD : 64'h1234_5678 + 64'(i));
        run(0);
        check("corrupt.err_cnt2", err_cnt, 2);
        check("corrupt.first_exp", first_exp, 64'h1234_567D);
        check("corrupt.first_got", first_got, 64'hDEAD);
        expect_run("corrupt", -1);

        reset_dut();
        check("rst_clear.err_cnt", err_cnt, 0);
        check("rst_clear.first_got", first_got, 0);
        check("rst_clear.done", done, 0);
        for (int i = 0; i < NW; i++) fifo.push_back(64'h1234_5678 + 64'(i));
        run(1);
        check("toggle.err_cnt0", err_cnt, 0);
        expect_run("toggle", -1);

        reset_dut();
        for (int i = 0; i < NW; i++) fifo.push_back(64'hFFFF_FFFF_FFFF_FFFE + 64'(i));
        run(0);
        check("wrap.err_cnt0", err_cnt, 0);
        expect_run("wrap", -1);

        reset_dut();
        for (int i = 0; i < 7; i++) fifo.push_back(64'h100 + 64'(i));
        en = 1'b1;
        n = 0;
        while (ren_cycles < 7 && n < 50) begin
            step(0);
            n++;
        end
        en = 1'b0;
        repeat (4) step(0);
        for (int i = 0; i < NW - 7; i++) fifo.push_back(64'h5000 + 64'(i));
        repeat (3) step(0);
        check("drop.reads_held", ren_cycles, 7);
        check("drop.pending_consumed", sent.size(), 7);
        check("drop.not_done", done, 0);
        run(0);
        expect_run("drop", 7);

        for (int r = 0; r < 6; r++) begin
            reset_dut();
            w = r == 0 ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
            for (int i = 0; i < NW; i++) begin
                fifo.push_back(w);
                w = ($urandom_range(0, 5) == 0) ? {$urandom, $urandom} : w + 64'd1;
            end
            run(2);
            expect_run("rand", -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
